// File: rtl/atm_pkg.sv
// ATM session controller shared types.
// State encoding, request field encodings, default sizing.
package atm_pkg;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_PIN    = 4'd1,
    S_MENU   = 4'd2,
    S_FACE   = 4'd3,
    S_EXEC   = 4'd4,
    S_EJECT  = 4'd5,
    S_LOCKED = 4'd6
  } state_t;

  localparam logic TM_BALANCE = 1'b0;
  localparam logic TM_MONEY   = 1'b1;

  localparam logic DW_DEPOSIT  = 1'b0;
  localparam logic DW_WITHDRAW = 1'b1;

  localparam int DEF_AMT_W        = 4;
  localparam int DEF_BAL_W        = 8;
  localparam int DEF_MAX_ATTEMPTS = 3;
  localparam int DEF_HIGH_LIMIT   = 10;
  localparam int DEF_INIT_BALANCE = 20;
  localparam int DEF_TIMEOUT_CYC  = 16;

endpackage

// File: rtl/atm_balance_alu.sv
// Balance add/subtract datapath.
// Flags carry-out on deposit and borrow on withdraw.
module atm_balance_alu #(
  parameter int AMT_W = 4,
  parameter int BAL_W = 8
) (
  input  logic [BAL_W-1:0] bal,
  input  logic [AMT_W-1:0] amt,
  output logic [BAL_W-1:0] sum,
  output logic [BAL_W-1:0] diff,
  output logic             ovf,
  output logic             udf
);

  logic [BAL_W-1:0] amt_x;
  logic [BAL_W:0]   wide;

  assign amt_x = BAL_W'(amt);
  assign wide  = {1'b0, bal} + {1'b0, amt_x};
  assign sum   = wide[BAL_W-1:0];
  assign ovf   = wide[BAL_W];
  assign diff  = bal - amt_x;
  assign udf   = amt_x > bal;

endmodule

// File: rtl/atm_txn_controller.sv
// ATM session controller: card, PIN, face gate,
// balance arithmetic and inactivity eject.
module atm_txn_controller
  import atm_pkg::*;
#(
  parameter int AMT_W        = DEF_AMT_W,
  parameter int BAL_W        = DEF_BAL_W,
  parameter int MAX_ATTEMPTS = DEF_MAX_ATTEMPTS,
  parameter int HIGH_LIMIT   = DEF_HIGH_LIMIT,
  parameter int INIT_BALANCE = DEF_INIT_BALANCE,
  parameter int TIMEOUT_CYC  = DEF_TIMEOUT_CYC
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             insert_card,
  input  logic             pin_strobe,
  input  logic             PIN,
  input  logic             transac_mode,
  input  logic             deposit_withdraw,
  input  logic             req_valid,
  input  logic [AMT_W-1:0] Amount,
  input  logic             face_recog,
  output logic [3:0]       state_o,
  output logic [2:0]       attempt,
  output logic             pin_locked,
  output logic             above_limit,
  output logic             transaction,
  output logic             txn_reject,
  output logic             timeout,
  output logic [BAL_W-1:0] new_balance
);

  localparam int TW = $clog2(TIMEOUT_CYC);
  localparam logic [TW-1:0] CNT_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [2:0] ATT_MAX = 3'(MAX_ATTEMPTS);

  state_t           state_q, state_d;
  logic [2:0]       att_q, att_d, att_inc;
  logic             lock_q, lock_d;
  logic             above_q, above_d;
  logic [BAL_W-1:0] bal_q, bal_d;
  logic [AMT_W-1:0] amt_q, amt_d;
  logic             dw_q, dw_d;
  logic [TW-1:0]    cnt_q, cnt_d;
  logic             txn_q, txn_d;
  logic             rej_q, rej_d;
  logic             tmo_q, tmo_d;
  logic [BAL_W-1:0] sum, diff;
  logic             ovf, udf;

  atm_balance_alu #(
    .AMT_W(AMT_W),
    .BAL_W(BAL_W)
  ) u_alu (
    .bal (bal_q),
    .amt (amt_q),
    .sum (sum),
    .diff(diff),
    .ovf (ovf),
    .udf (udf)
  );

  // Register all state and outputs; reset aborts any session.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      att_q   <= '0;
      lock_q  <= 1'b0;
      above_q <= 1'b0;
      bal_q   <= BAL_W'(INIT_BALANCE);
      amt_q   <= '0;
      dw_q    <= 1'b0;
      cnt_q   <= '0;
      txn_q   <= 1'b0;
      rej_q   <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      att_q   <= att_d;
      lock_q  <= lock_d;
      above_q <= above_d;
      bal_q   <= bal_d;
      amt_q   <= amt_d;
      dw_q    <= dw_d;
      cnt_q   <= cnt_d;
      txn_q   <= txn_d;
      rej_q   <= rej_d;
      tmo_q   <= tmo_d;
    end
  end

  // Next-state, datapath and pulse decode.
  always_comb begin
    state_d = state_q;
    att_d   = att_q;
    lock_d  = lock_q;
    above_d = above_q;
    bal_d   = bal_q;
    amt_d   = amt_q;
    dw_d    = dw_q;
    txn_d   = 1'b0;
    rej_d   = 1'b0;
    tmo_d   = 1'b0;
    att_inc = att_q + 3'd1;
    cnt_d   = '0;
    if (state_q == S_PIN || state_q == S_MENU)
      cnt_d = cnt_q + 1'b1;

    case (state_q)
      S_IDLE: begin
        if (insert_card) begin
          att_d   = '0;
          state_d = lock_q ? S_LOCKED : S_PIN;
        end
      end
      S_PIN: begin
        if (!insert_card) begin
          state_d = S_IDLE;
        end else if (pin_strobe) begin
          cnt_d = '0;
          if (PIN) begin
            state_d = S_MENU;
          end else begin
            att_d = att_inc;
            if (att_inc == ATT_MAX) begin
              lock_d  = 1'b1;
              state_d = S_LOCKED;
            end
          end
        end else if (cnt_q == CNT_LAST) begin
          tmo_d   = 1'b1;
          state_d = S_EJECT;
        end
      end
      S_MENU: begin
        if (!insert_card) begin
          state_d = S_IDLE;
        end else if (req_valid) begin
          cnt_d = '0;
          amt_d = Amount;
          dw_d  = deposit_withdraw;
          if (transac_mode == TM_BALANCE) begin
            state_d = S_EJECT;
          end else if (deposit_withdraw == DW_DEPOSIT) begin
            state_d = S_EXEC;
          end else begin
            above_d = 32'(Amount) > HIGH_LIMIT;
            state_d = above_d ? S_FACE : S_EXEC;
          end
        end else if (cnt_q == CNT_LAST) begin
          tmo_d   = 1'b1;
          state_d = S_EJECT;
        end
      end
      S_FACE: begin
        if (!insert_card) begin
          state_d = S_IDLE;
        end else if (face_recog) begin
          state_d = S_EXEC;
        end else begin
          rej_d   = 1'b1;
          state_d = S_EJECT;
        end
      end
      S_EXEC: begin
        state_d = S_EJECT;
        if (dw_q == DW_DEPOSIT) begin
          rej_d = ovf;
          txn_d = !ovf;
          if (!ovf) bal_d = sum;
        end else begin
          rej_d = udf;
          txn_d = !udf;
          if (!udf) bal_d = diff;
        end
      end
      S_EJECT, S_LOCKED: begin
        if (!insert_card) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (state_d != state_q) cnt_d = '0;
  end

  assign state_o     = state_q;
  assign attempt     = att_q;
  assign pin_locked  = lock_q;
  assign above_limit = above_q;
  assign transaction = txn_q;
  assign txn_reject  = rej_q;
  assign timeout     = tmo_q;
  assign new_balance = bal_q;

endmodule

// File: tb/tb_atm_txn_controller.sv
// Scoreboard bench for atm_txn_controller.
// Stimulus pushes expected pulses; a monitor pops and compares.
module tb_atm_txn_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic       insert_card;
  logic       pin_strobe;
  logic       PIN;
  logic       transac_mode;
  logic       deposit_withdraw;
  logic       req_valid;
  logic [3:0] Amount;
  logic       face_recog;
  logic [3:0] state_o;
  logic [2:0] attempt;
  logic       pin_locked;
  logic       above_limit;
  logic       transaction;
  logic       txn_reject;
  logic       timeout;
  logic [7:0] new_balance;

  localparam logic [2:0] K_TXN = 3'b001;
  localparam logic [2:0] K_REJ = 3'b010;
  localparam logic [2:0] K_TMO = 3'b100;

  localparam logic [3:0] ST_IDLE   = 4'd0;
  localparam logic [3:0] ST_PIN    = 4'd1;
  localparam logic [3:0] ST_MENU   = 4'd2;
  localparam logic [3:0] ST_FACE   = 4'd3;
  localparam logic [3:0] ST_EXEC   = 4'd4;
  localparam logic [3:0] ST_EJECT  = 4'd5;
  localparam logic [3:0] ST_LOCKED = 4'd6;

  typedef struct packed {
    logic [2:0] kind;
    logic [7:0] bal;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_bad = 0;
  int   exp_bal;

  atm_txn_controller dut (
    .clk             (clk),
    .reset           (reset),
    .insert_card     (insert_card),
    .pin_strobe      (pin_strobe),
    .PIN             (PIN),
    .transac_mode    (transac_mode),
    .deposit_withdraw(deposit_withdraw),
    .req_valid       (req_valid),
    .Amount          (Amount),
    .face_recog      (face_recog),
    .state_o         (state_o),
    .attempt         (attempt),
    .pin_locked      (pin_locked),
    .above_limit     (above_limit),
    .transaction     (transaction),
    .txn_reject      (txn_reject),
    .timeout         (timeout),
    .new_balance     (new_balance)
  );

  always #5 clk = ~clk;

  // Monitor: every pulse must match the oldest expected event.
  always @(negedge clk) begin
    logic [2:0] k;
    exp_t e;
    k = {timeout, txn_reject, transaction};
    if (reset && k != 3'b000) begin
      n_vec++;
      if (q.size() == 0) begin
        n_bad++;
        $display("FAIL pulse: got kind %b bal %0d, none expected",
                 k, new_balance);
      end else begin
        e = q.pop_front();
        if (k != e.kind || new_balance != e.bal) begin
          n_bad++;
          $display("FAIL pulse: got kind %b bal %0d, want kind %b bal %0d",
                   k, new_balance, e.kind, e.bal);
        end
      end
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_ev(input logic [2:0] k, input int b);
    exp_t e;
    e.kind = k;
    e.bal  = 8'(b);
    q.push_back(e);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick(2);
    reset = 1'b1;
    exp_bal = 20;
  endtask

  task automatic strobe_pin(input logic p);
    pin_strobe = 1'b1;
    PIN = p;
    tick(1);
    pin_strobe = 1'b0;
  endtask

  task automatic request(input logic m, input logic dw, input int a);
    req_valid = 1'b1;
    transac_mode = m;
    deposit_withdraw = dw;
    Amount = 4'(a);
    tick(1);
    req_valid = 1'b0;
  endtask

  task automatic open_session();
    insert_card = 1'b1;
    tick(1);
    strobe_pin(1'b1);
  endtask

  task automatic close_session();
    insert_card = 1'b0;
    tick(1);
  endtask

  // Full money session; the model decides commit or reject.
  task automatic money(input logic dw, input int a, input logic f);
    open_session();
    face_recog = f;
    if (dw && a > 10) begin
      request(1'b1, dw, a);
      if (!f) begin
        expect_ev(K_REJ, exp_bal);
        tick(1);
        close_session();
        return;
      end
      tick(1);
    end else begin
      request(1'b1, dw, a);
    end
    if (!dw && exp_bal + a > 255) expect_ev(K_REJ, exp_bal);
    else if (dw && a > exp_bal) expect_ev(K_REJ, exp_bal);
    else begin
      exp_bal = dw ? exp_bal - a : exp_bal + a;
      expect_ev(K_TXN, exp_bal);
    end
    tick(1);
    chk("exec_to_eject", state_o, ST_EJECT);
    chk("bal_after", new_balance, exp_bal);
    close_session();
  endtask

  initial begin
    reset = 1'b1;
    insert_card = 1'b0;
    pin_strobe = 1'b0;
    PIN = 1'b0;
    transac_mode = 1'b0;
    deposit_withdraw = 1'b0;
    req_valid = 1'b0;
    Amount = '0;
    face_recog = 1'b0;
    tick(1);
    do_reset();

    chk("rst_state", state_o, ST_IDLE);
    chk("rst_attempt", attempt, 0);
    chk("rst_locked", pin_locked, 0);
    chk("rst_above", above_limit, 0);
    chk("rst_bal", new_balance, 20);
    chk("rst_pulses", {timeout, txn_reject, transaction}, 0);

    // Plain withdraw 5: 20 -> 15.
    insert_card = 1'b1;
    tick(1);
    chk("idle_to_pin", state_o, ST_PIN);
    strobe_pin(1'b1);
    chk("pin_to_menu", state_o, ST_MENU);
    request(1'b1, 1'b1, 5);
    chk("menu_to_exec", state_o, ST_EXEC);
    exp_bal = 15;
    expect_ev(K_TXN, 15);
    tick(1);
    chk("w5_eject", state_o, ST_EJECT);
    chk("w5_bal", new_balance, 15);
    close_session();
    chk("eject_to_idle", state_o, ST_IDLE);

    // PIN lockout after three wrong entries.
    insert_card = 1'b1;
    tick(1);
    strobe_pin(1'b0);
    chk("att1", attempt, 1);
    chk("att1_state", state_o, ST_PIN);
    strobe_pin(1'b0);
    chk("att2", attempt, 2);
    strobe_pin(1'b0);
    chk("att3", attempt, 3);
    chk("locked", pin_locked, 1);
    chk("locked_state", state_o, ST_LOCKED);
    close_session();
    chk("locked_out", state_o, ST_IDLE);
    insert_card = 1'b1;
    tick(1);
    chk("relock", state_o, ST_LOCKED);
    close_session();
    do_reset();
    chk("unlock", pin_locked, 0);
    chk("unlock_bal", new_balance, 20);

    // High-value withdraw: face fail then face pass.
    open_session();
    face_recog = 1'b0;
    request(1'b1, 1'b1, 11);
    chk("face_state", state_o, ST_FACE);
    chk("above", above_limit, 1);
    expect_ev(K_REJ, 20);
    tick(1);
    chk("face_rej_bal", new_balance, 20);
    chk("face_rej_state", state_o, ST_EJECT);
    close_session();
    money(1'b1, 11, 1'b1);
    chk("face_ok_bal", new_balance, 9);

    // Overdraft, then climb to 250 and overflow.
    money(1'b1, 15, 1'b1);
    chk("overdraft_above", above_limit, 1);
    for (int i = 0; i < 16; i++) money(1'b0, 15, 1'b0);
    money(1'b0, 1, 1'b0);
    chk("bal_250", new_balance, 250);
    money(1'b0, 15, 1'b0);
    chk("ovf_keep", new_balance, 250);
    money(1'b0, 5, 1'b0);
    chk("bal_max", new_balance, 255);
    money(1'b1, 0, 1'b0);
    chk("w0_above", above_limit, 0);

    // Balance enquiry: no pulse, straight to eject.
    open_session();
    request(1'b0, 1'b1, 3);
    chk("enq_state", state_o, ST_EJECT);
    chk("enq_bal", new_balance, 255);
    close_session();

    // Inactivity in MENU for 16 cycles.
    open_session();
    tick(15);
    chk("tmo_not_yet", state_o, ST_MENU);
    expect_ev(K_TMO, 255);
    tick(1);
    chk("tmo_eject", state_o, ST_EJECT);
    chk("tmo_bal", new_balance, 255);
    close_session();

    // Reset during FACE aborts with no commit.
    open_session();
    face_recog = 1'b1;
    request(1'b1, 1'b1, 12);
    chk("abort_face", state_o, ST_FACE);
    reset = 1'b0;
    insert_card = 1'b0;
    tick(1);
    reset = 1'b1;
    exp_bal = 20;
    chk("abort_state", state_o, ST_IDLE);
    chk("abort_bal", new_balance, 20);
    chk("abort_above", above_limit, 0);

    // Card pulled in PIN, racing a strobe.
    insert_card = 1'b1;
    tick(1);
    insert_card = 1'b0;
    strobe_pin(1'b1);
    chk("pull_state", state_o, ST_IDLE);
    chk("pull_bal", new_balance, 20);
    tick(2);

    for (int i = 0; i < 20 && q.size() != 0; i++) tick(1);
    if (q.size() != 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL drain: got %0d pending, want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/atm_txn_controller.md
Name: atm_txn_controller

Overview:
Parametrised next-generation ATM session controller for the ATM FSM design. It sequences card insertion, a PIN check with a configurable attempt limit and lockout, and a face-recognition gate for high-value withdrawals. It also handles deposit and withdraw arithmetic with overdraft rejection, and ejects the card after an inactivity timeout. It sits between the card/keypad/camera front-end inputs and the display/dispense outputs.

Parameters:
AMT_W, 4, width of amount input
BAL_W, 8, width of balance register (BAL_W >= AMT_W)
MAX_ATTEMPTS, 3, wrong PIN entries before lockout (1..7)
HIGH_LIMIT, 10, withdraw amounts strictly greater than this require face_recog
INIT_BALANCE, 20, balance value loaded at reset
TIMEOUT_CYC, 16, idle cycles in a session state before forced eject (>=2)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-low reset
insert_card  in  1  level; 1 = card present
pin_strobe  in  1  one-cycle pulse; PIN entry complete
PIN  in  1  sampled with pin_strobe; 1 = PIN correct
transac_mode  in  1  sampled in MENU with req_valid; 0 = balance enquiry, 1 = money transaction
deposit_withdraw  in  1  sampled with req_valid; 0 = deposit, 1 = withdraw
req_valid  in  1  one-cycle pulse; request fields valid
Amount  in  AMT_W  transaction amount, sampled with req_valid
face_recog  in  1  level; 1 = face matched, sampled in FACE state
state_o  out  4  current state encoding (debug)
attempt  out  3  wrong-PIN count this session
pin_locked  out  1  sticky lockout flag
above_limit  out  1  registered; last withdraw request exceeded HIGH_LIMIT
transaction  out  1  one-cycle pulse; deposit/withdraw committed
txn_reject  out  1  one-cycle pulse; request refused (overdraft, face fail, overflow)
timeout  out  1  one-cycle pulse; session ended by inactivity
new_balance  out  BAL_W  current balance register

Behaviour:
- All outputs are registered. Reset (reset==0 at a clk edge) forces: state IDLE, attempt 0, pin_locked 0, above_limit 0, all pulses 0, new_balance INIT_BALANCE. Reset mid-session aborts with no commit.
- States: IDLE, PIN, MENU, FACE, EXEC, EJECT, LOCKED.
- IDLE: on insert_card==1 go to PIN; attempt cleared. If pin_locked==1, go to LOCKED instead.
- PIN: on pin_strobe with PIN==1 go to MENU.
  - On pin_strobe with PIN==0, increment attempt.
  - If the incremented value == MAX_ATTEMPTS, set pin_locked and go to LOCKED; otherwise stay in PIN.
- LOCKED: pin_locked stays 1 until reset. Ignores all inputs except insert_card==0, which returns to IDLE. Re-insert goes straight back to LOCKED.
- MENU, on req_valid:
  - transac_mode==0: no balance change; go to EJECT.
  - transac_mode==1, deposit: go to EXEC.
  - transac_mode==1, withdraw: above_limit <= (Amount > HIGH_LIMIT). Go to FACE if above the limit, else EXEC.
  - Amount is latched into an internal register on req_valid.
- FACE: one-cycle check. face_recog==1 goes to EXEC; 0 pulses txn_reject and goes to EJECT.
- EXEC: one cycle.
  - Deposit: if latched Amount + balance exceeds 2^BAL_W-1, pulse txn_reject and leave balance unchanged; else add and pulse transaction.
  - Withdraw: if Amount > balance, pulse txn_reject; else subtract and pulse transaction.
  - Withdraw of exactly the balance is legal and leaves 0. Amount 0 is legal and commits with no change.
  - Then go to EJECT. new_balance updates on the same edge that transaction is asserted.
- EJECT: wait for insert_card==0, then go to IDLE. Balance persists across sessions.
- Card removal: insert_card==0 in PIN, MENU or FACE returns to IDLE with no commit. EXEC always completes.
- Timeout:
  - Idle counter runs in PIN and MENU, and clears on any pin_strobe or req_valid or on state change.
  - On reaching TIMEOUT_CYC, pulse timeout and go to EJECT.
- Simultaneous events: reset has priority over everything; card removal over strobe/request; pin_strobe and req_valid are ignored outside their own state.

Decomposition:
- Package atm_pkg: state enum (4-bit), encodings for transac_mode and deposit_withdraw, and a default-parameter constants block.
- One natural sub-module, atm_balance_alu: combinational add/sub with overflow and underflow flags, parametrised by AMT_W and BAL_W. All registers stay in the top-level block.

Test Plan:
1. Reset, insert card, PIN=1, withdraw Amount=5 -> transaction pulse, new_balance 20->15, EJECT; remove card -> IDLE.
2. Three pin_strobe with PIN=0 -> attempt 1,2,3, pin_locked=1, LOCKED. Remove and reinsert -> LOCKED again. Reset -> pin_locked=0, balance 20.
3. Withdraw Amount=11: face_recog=0 -> above_limit=1, txn_reject, balance unchanged. Repeat with face_recog=1 -> balance 20->9.
4. Withdraw Amount=15 with balance 9 -> txn_reject, balance 9. Deposit 15 at balance 250 -> txn_reject, 250 retained.
5. Insert card, valid PIN, no request for 16 cycles in MENU -> timeout pulse, EJECT, balance unchanged.
6. Reset asserted during FACE, and card pulled during PIN -> IDLE, no transaction pulse; balance INIT_BALANCE and unchanged respectively.
